// File: rtl/block_product_2x2.sv
// 2x2 single-precision block product C = A*B. Two multiply passes and one add pass
// over four multiplier and four adder cores; the block itself only sequences and latches.

module multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] Number1,
  input  logic [31:0] Number2,
  input  logic        result_ack,
  output logic [31:0] Result,
  output logic        result_ready
);
  localparam logic [1:0] LAT = 2'd3;

  logic [1:0]  cnt;
  logic [47:0] prod;
  logic [9:0]  e;
  logic [31:0] res_c;

  // Truncating multiply; zero/denormal inputs and underflow give +0, overflow gives Inf.
  always_comb begin
    prod  = {24'd0, 1'b1, Number1[22:0]} * {24'd0, 1'b1, Number2[22:0]};
    e     = {2'b0, Number1[30:23]} + {2'b0, Number2[30:23]} + {9'd0, prod[47]} - 10'd127;
    res_c = {Number1[31] ^ Number2[31], e[7:0], prod[47] ? prod[46:24] : prod[45:23]};
    if (Number1[30:23] == 8'd0 || Number2[30:23] == 8'd0 || e[9] || e == 10'd0)
      res_c = 32'd0;
    else if (e >= 10'd255)
      res_c = {Number1[31] ^ Number2[31], 8'hFF, 23'd0};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt          <= 2'd0;
      Result       <= 32'd0;
      result_ready <= 1'b0;
    end else if (load) begin
      cnt          <= LAT;
      Result       <= res_c;
      result_ready <= 1'b0;
    end else if (result_ack) begin
      result_ready <= 1'b0;
    end else if (cnt != 2'd0) begin
      cnt          <= cnt - 2'd1;
      result_ready <= (cnt == 2'd1);
    end
  end
endmodule

module adder (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] Number1,
  input  logic [31:0] Number2,
  input  logic        result_ack,
  output logic [31:0] Result,
  output logic        result_ready
);
  localparam logic [1:0] LAT = 2'd2;

  logic [1:0]  cnt;
  logic [31:0] x, y;
  logic [7:0]  d;
  logic [26:0] mx, my;
  logic [27:0] s, t;
  logic [4:0]  p, sh;
  logic [9:0]  e;
  logic [31:0] res_c;

  // x is the larger magnitude, so the result takes its sign; exact cancellation gives +0.
  always_comb begin
    if (Number1[30:0] >= Number2[30:0]) begin
      x = Number1;
      y = Number2;
    end else begin
      x = Number2;
      y = Number1;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = (y[30:23] == 8'd0) ? 27'd0 : ({1'b1, y[22:0], 3'b000} >> d);
    s  = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
    p  = 5'd0;
    for (int i = 0; i < 28; i++)
      if (s[i]) p = 5'(i);
    sh = 5'd26 - p;
    t  = s << sh;
    if (s[27]) e = {2'b0, x[30:23]} + 10'd1;
    else       e = {2'b0, x[30:23]} - {5'd0, sh};
    res_c = {x[31], e[7:0], s[27] ? s[26:4] : t[25:3]};
    if (x[30:23] == 8'd0 || s == 28'd0 || e[9] || e == 10'd0)
      res_c = 32'd0;
    else if (e >= 10'd255)
      res_c = {x[31], 8'hFF, 23'd0};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt          <= 2'd0;
      Result       <= 32'd0;
      result_ready <= 1'b0;
    end else if (load) begin
      cnt          <= LAT;
      Result       <= res_c;
      result_ready <= 1'b0;
    end else if (result_ack) begin
      result_ready <= 1'b0;
    end else if (cnt != 2'd0) begin
      cnt          <= cnt - 2'd1;
      result_ready <= (cnt == 2'd1);
    end
  end
endmodule

module block_product_2x2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] i_a11,
  input  logic [W-1:0] i_a12,
  input  logic [W-1:0] i_a21,
  input  logic [W-1:0] i_a22,
  input  logic [W-1:0] i_b11,
  input  logic [W-1:0] i_b12,
  input  logic [W-1:0] i_b21,
  input  logic [W-1:0] i_b22,
  input  logic         out_ready,
  output logic [W-1:0] o_c11,
  output logic [W-1:0] o_c12,
  output logic [W-1:0] o_c21,
  output logic [W-1:0] o_c22,
  output logic         busy,
  output logic         done,
  output logic [2:0]   state_dbg
);
  typedef enum logic [2:0] {
    S_IDLE, S_MUL1_LD, S_MUL1_WT, S_MUL2_LD, S_MUL2_WT, S_ADD_LD, S_ADD_WT, S_OUT
  } state_t;

  state_t state, state_nx;
  logic [W-1:0] a_q [4];
  logic [W-1:0] b_q [4];
  logic [W-1:0] p1_q [4];
  logic [W-1:0] p2_q [4];
  logic [W-1:0] c_q [4];
  logic [W-1:0] m_n1 [4];
  logic [W-1:0] m_n2 [4];
  logic [W-1:0] m_res [4];
  logic [W-1:0] a_res [4];
  logic [3:0]   m_rdy, a_rdy;
  logic m_rst_n, m_load, m_ack, a_rst_n, a_load, a_ack, pass2, m_all, a_all;

  assign pass2 = (state == S_MUL2_LD) || (state == S_MUL2_WT);
  assign m_all = &m_rdy;
  assign a_all = &a_rdy;

  // Core k computes c(row,col): pass 1 multiplies aR1*b1C, pass 2 aR2*b2C, the adder sums them.
  for (genvar k = 0; k < 4; k++) begin : g_core
    localparam int R = k / 2;
    localparam int C = k % 2;
    assign m_n1[k] = pass2 ? a_q[2*R+1] : a_q[2*R];
    assign m_n2[k] = pass2 ? b_q[2+C]   : b_q[C];
    multiplier u_mul (
      .clk(clk), .reset(m_rst_n), .load(m_load), .Number1(m_n1[k]), .Number2(m_n2[k]),
      .result_ack(m_ack), .Result(m_res[k]), .result_ready(m_rdy[k])
    );
    adder u_add (
      .clk(clk), .reset(a_rst_n), .load(a_load), .Number1(p1_q[k]), .Number2(p2_q[k]),
      .result_ack(a_ack), .Result(a_res[k]), .result_ready(a_rdy[k])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Handshake: done is high only in S_OUT while out_ready is high; that cycle is the transfer.
  always_comb begin
    state_nx = state;
    m_rst_n  = 1'b0;
    m_load   = 1'b0;
    m_ack    = 1'b0;
    a_rst_n  = 1'b0;
    a_load   = 1'b0;
    a_ack    = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_MUL1_LD;
      S_MUL1_LD, S_MUL2_LD: begin
        m_rst_n  = 1'b1;
        m_load   = 1'b1;
        state_nx = (state == S_MUL1_LD) ? S_MUL1_WT : S_MUL2_WT;
      end
      S_MUL1_WT, S_MUL2_WT: begin
        m_rst_n = 1'b1;
        if (m_all) begin
          m_ack    = 1'b1;
          m_rst_n  = 1'b0;
          state_nx = (state == S_MUL1_WT) ? S_MUL2_LD : S_ADD_LD;
        end
      end
      S_ADD_LD: begin
        a_rst_n  = 1'b1;
        a_load   = 1'b1;
        state_nx = S_ADD_WT;
      end
      S_ADD_WT: begin
        a_rst_n = 1'b1;
        if (a_all) begin
          a_ack    = 1'b1;
          a_rst_n  = 1'b0;
          state_nx = S_OUT;
        end
      end
      S_OUT: if (out_ready) begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        p1_q[k] <= '0;
        p2_q[k] <= '0;
        c_q[k]  <= '0;
      end
    end else begin
      if (state == S_IDLE && start) begin
        a_q[0] <= i_a11; a_q[1] <= i_a12; a_q[2] <= i_a21; a_q[3] <= i_a22;
        b_q[0] <= i_b11; b_q[1] <= i_b12; b_q[2] <= i_b21; b_q[3] <= i_b22;
      end
      for (int k = 0; k < 4; k++) begin
        if (state == S_MUL1_WT && m_all) p1_q[k] <= m_res[k];
        if (state == S_MUL2_WT && m_all) p2_q[k] <= m_res[k];
        if (state == S_ADD_WT  && a_all) c_q[k]  <= a_res[k];
      end
    end
  end

  assign o_c11     = c_q[0];
  assign o_c12     = c_q[1];
  assign o_c21     = c_q[2];
  assign o_c22     = c_q[3];
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;
endmodule
